// File: rtl/if_stage_fetch_buf_pkg.sv
// Shared definitions for the fetch stage: ring entry states and fs->ds bus layout.
// Bus layout is {ex, badvaddr, inst, pc}, MSB first.
package if_stage_fetch_buf_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_PEND  = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic int fs_to_ds_bus_wd(input int pc_w, input int inst_w);
      return 1 + 2 * pc_w + inst_w;
   endfunction

   // Field LSB positions for the default 32-bit PC / instruction widths
   localparam int FS_TO_DS_BUS_WD = fs_to_ds_bus_wd(32, 32);
   localparam int BUS_PC_LSB      = 0;
   localparam int BUS_INST_LSB    = 32;
   localparam int BUS_BADV_LSB    = 64;
   localparam int BUS_EX_BIT      = 96;

endpackage

// File: rtl/fetch_ring_buf.sv
// In-order ring of fetch entries: allocate at tail, complete the oldest PEND
// entry on a response, retire at head; flush empties everything.
module fetch_ring_buf
   import if_stage_fetch_buf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         alloc,
   input  logic                         alloc_ex,
   input  logic [PC_W-1:0]              alloc_pc,
   input  logic                         resp,
   input  logic [INST_W-1:0]            resp_data,
   input  logic                         retire,
   output logic                         head_done,
   output logic                         head_ex,
   output logic [PC_W-1:0]              head_pc,
   output logic [INST_W-1:0]            head_inst,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [$clog2(DEPTH+1)-1:0]   pend_cnt,
   output logic                         has_pend
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0][1:0]        state;
   logic [DEPTH-1:0]             ex_q;
   logic [DEPTH-1:0][PC_W-1:0]   pc_q;
   logic [DEPTH-1:0][INST_W-1:0] inst_q;
   logic [PTR_W-1:0]             head, tail, pend_idx, idx;
   logic [CNT_W-1:0]             occ;

   // Walk from head so the first PEND found is the oldest outstanding fetch
   always_comb begin
      pend_idx = head;
      has_pend = 1'b0;
      pend_cnt = '0;
      idx      = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (state[idx] == ST_PEND && !has_pend) begin
            has_pend = 1'b1;
            pend_idx = idx;
         end
         if (state[i] == ST_PEND) pend_cnt = pend_cnt + CNT_W'(1);
      end
   end

   assign head_done = (state[head] == ST_DONE);
   assign head_ex   = ex_q[head];
   assign head_pc   = pc_q[head];
   assign head_inst = inst_q[head];
   assign occupancy = occ;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= '0;
         ex_q   <= '0;
         pc_q   <= '0;
         inst_q <= '0;
         head   <= '0;
         tail   <= '0;
         occ    <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) state[i] <= ST_EMPTY;
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         // alloc, resp and retire always target distinct slots
         if (alloc) begin
            state[tail]  <= alloc_ex ? ST_DONE : ST_PEND;
            ex_q[tail]   <= alloc_ex;
            pc_q[tail]   <= alloc_pc;
            inst_q[tail] <= '0;
            tail         <= tail + PTR_W'(1);
         end
         if (resp) begin
            state[pend_idx]  <= ST_DONE;
            inst_q[pend_idx] <= resp_data;
         end
         if (retire) begin
            state[head] <= ST_EMPTY;
            head        <= head + PTR_W'(1);
         end
         occ <= occ + CNT_W'(alloc) - CNT_W'(retire);
      end
   end

endmodule

// File: rtl/if_stage_fetch_buf.sv
// Fetch stage between pre-fetch and decode: issues inst_sram requests, buffers
// results in order, and drops responses owed to flushed fetches.
module if_stage_fetch_buf
   import if_stage_fetch_buf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     pfs_to_fs_valid,
   input  logic [PC_W-1:0]                          pfs_pc,
   output logic                                     fs_allowin,
   output logic                                     inst_sram_req,
   output logic [PC_W-1:0]                          inst_sram_addr,
   input  logic                                     inst_sram_addr_ok,
   input  logic                                     inst_sram_data_ok,
   input  logic [INST_W-1:0]                        inst_sram_rdata,
   input  logic                                     ds_allowin,
   output logic                                     fs_to_ds_valid,
   output logic [fs_to_ds_bus_wd(PC_W, INST_W)-1:0] fs_to_ds_bus,
   input  logic                                     ws_ex,
   input  logic                                     ws_eret,
   output logic [$clog2(DEPTH+1)-1:0]               fs_occupancy
);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic              flush, mis, room, accept, retire, resp;
   logic              head_done, head_ex, has_pend;
   logic [PC_W-1:0]   head_pc;
   logic [INST_W-1:0] head_inst;
   logic [CNT_W-1:0]  occ, pend_cnt, cancel_cnt, owed;

   assign flush = ws_ex | ws_eret;
   assign mis   = (pfs_pc[1:0] != 2'b00);
   // pend_cnt + cancel_cnt never exceeds DEPTH, so CNT_W bits suffice
   assign room  = (occ < CNT_W'(DEPTH)) && ((pend_cnt + cancel_cnt) < CNT_W'(DEPTH));

   // Combinational outputs are forced low while reset is held
   assign inst_sram_req  = reset & pfs_to_fs_valid & !mis & room & !flush;
   assign inst_sram_addr = reset ? pfs_pc : '0;
   assign fs_allowin     = reset & room & !flush & (mis | inst_sram_addr_ok);
   assign accept         = pfs_to_fs_valid & fs_allowin;

   assign fs_to_ds_valid = reset & head_done & !flush;
   assign retire         = fs_to_ds_valid & ds_allowin;
   assign fs_to_ds_bus   = {head_ex, head_pc, head_inst, head_pc};
   assign fs_occupancy   = occ;

   assign resp = inst_sram_data_ok & (cancel_cnt == '0) & has_pend & !flush;

   // On flush every PEND becomes owed; a same-cycle response pays off the oldest debt
   always_comb begin
      owed = cancel_cnt + pend_cnt;
      if (inst_sram_data_ok && owed != '0) owed = owed - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cancel_cnt <= '0;
      else if (flush)
         cancel_cnt <= owed;
      else if (inst_sram_data_ok && cancel_cnt != '0)
         cancel_cnt <= cancel_cnt - CNT_W'(1);
   end

   fetch_ring_buf #(
      .DEPTH  (DEPTH),
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) u_ring (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .alloc     (accept),
      .alloc_ex  (mis),
      .alloc_pc  (pfs_pc),
      .resp      (resp),
      .resp_data (inst_sram_rdata),
      .retire    (retire),
      .head_done (head_done),
      .head_ex   (head_ex),
      .head_pc   (head_pc),
      .head_inst (head_inst),
      .occupancy (occ),
      .pend_cnt  (pend_cnt),
      .has_pend  (has_pend)
   );

endmodule

// File: tb/tb_if_stage_fetch_buf.sv
// Directed, table-driven bench for if_stage_fetch_buf (DEPTH=4): one row per cycle,
// outputs sampled on the falling edge against hand-computed expectations.
module tb_if_stage_fetch_buf;
   localparam int DEPTH  = 4;
   localparam int PC_W   = 32;
   localparam int INST_W = 32;
   localparam int BUS_W  = 1 + 2*PC_W + INST_W;
   localparam int OCC_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              reset;
   logic              pfs_to_fs_valid;
   logic [PC_W-1:0]   pfs_pc;
   logic              fs_allowin, inst_sram_req;
   logic [PC_W-1:0]   inst_sram_addr;
   logic              inst_sram_addr_ok, inst_sram_data_ok;
   logic [INST_W-1:0] inst_sram_rdata;
   logic              ds_allowin, fs_to_ds_valid;
   logic [BUS_W-1:0]  fs_to_ds_bus;
   logic              ws_ex, ws_eret;
   logic [OCC_W-1:0]  fs_occupancy;

   typedef struct {
      logic             pv;
      logic [31:0]      pc;
      logic             aok;
      logic             dok;
      logic [31:0]      rd;
      logic             dsa;
      logic [1:0]       fl;   // {eret, ex}
      logic             ea;   // expected fs_allowin
      logic             er;   // expected inst_sram_req
      logic             ev;   // expected fs_to_ds_valid
      logic [BUS_W-1:0] eb;
      logic [OCC_W-1:0] eo;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   if_stage_fetch_buf #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .pfs_to_fs_valid   (pfs_to_fs_valid),
      .pfs_pc            (pfs_pc),
      .fs_allowin        (fs_allowin),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .ds_allowin        (ds_allowin),
      .fs_to_ds_valid    (fs_to_ds_valid),
      .fs_to_ds_bus      (fs_to_ds_bus),
      .ws_ex             (ws_ex),
      .ws_eret           (ws_eret),
      .fs_occupancy      (fs_occupancy)
   );

   function automatic logic [BUS_W-1:0] bus(input logic ex, input logic [31:0] pc,
                                            input logic [31:0] inst);
      return {ex, pc, inst, pc};
   endfunction

   function automatic vec_t mk(input logic pv, input logic [31:0] pc, input logic aok,
                               input logic dok, input logic [31:0] rd, input logic dsa,
                               input logic [1:0] fl, input logic ea, input logic er,
                               input logic ev, input logic [BUS_W-1:0] eb,
                               input logic [OCC_W-1:0] eo);
      vec_t v;
      v.pv = pv; v.pc = pc; v.aok = aok; v.dok = dok; v.rd = rd; v.dsa = dsa; v.fl = fl;
      v.ea = ea; v.er = er; v.ev = ev; v.eb = eb; v.eo = eo;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      pfs_to_fs_valid   = v.pv;
      pfs_pc            = v.pc;
      inst_sram_addr_ok = v.aok;
      inst_sram_data_ok = v.dok;
      inst_sram_rdata   = v.rd;
      ds_allowin        = v.dsa;
      ws_ex             = v.fl[0];
      ws_eret           = v.fl[1];
   endtask

   // Called at posedge+1; drives the row, checks at the falling edge, returns at posedge+1
   task automatic apply(input string tag, input vec_t v);
      drive(v);
      @(negedge clk);
      chk({tag, ".allowin"}, BUS_W'(fs_allowin),     BUS_W'(v.ea));
      chk({tag, ".req"},     BUS_W'(inst_sram_req),  BUS_W'(v.er));
      chk({tag, ".valid"},   BUS_W'(fs_to_ds_valid), BUS_W'(v.ev));
      chk({tag, ".occ"},     BUS_W'(fs_occupancy),   BUS_W'(v.eo));
      if (v.er) chk({tag, ".addr"}, BUS_W'(inst_sram_addr), BUS_W'(v.pc));
      if (v.ev) chk({tag, ".bus"},  fs_to_ds_bus, v.eb);
      @(posedge clk);
      #1;
   endtask

   task automatic run_tbl(input string tag);
      for (int i = 0; i < tbl.size(); i++) apply($sformatf("%s[%0d]", tag, i), tbl[i]);
      tbl.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".req"},     BUS_W'(inst_sram_req),  '0);
      chk({tag, ".allowin"}, BUS_W'(fs_allowin),     '0);
      chk({tag, ".addr"},    BUS_W'(inst_sram_addr), '0);
      chk({tag, ".valid"},   BUS_W'(fs_to_ds_valid), '0);
      chk({tag, ".occ"},     BUS_W'(fs_occupancy),   '0);
      chk({tag, ".bus"},     fs_to_ds_bus,           '0);
   endtask

   initial begin
      // Reset held with an aligned, acknowledged PC on the inputs: everything must stay 0
      reset = 1'b0;
      drive(mk(1, 32'h0000_0000, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: single aligned fetch, data_ok two cycles after accept
      tbl.push_back(mk(1, 32'hBFC0_0000, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 32'h2401_0001, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, bus(0, 32'hBFC0_0000, 32'h2401_0001), 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      run_tbl("single");

      // 2: fill to DEPTH under backpressure, then drain in order; 5th PC enters after first retire
      tbl.push_back(mk(1, 32'h0,  1, 0, 0,            0, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'h4,  1, 1, 32'hA000_0000, 0, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 32'h8,  1, 1, 32'hA000_0004, 0, 0, 1, 1, 1, bus(0, 32'h0, 32'hA000_0000), 2));
      tbl.push_back(mk(1, 32'hC,  1, 1, 32'hA000_0008, 0, 0, 1, 1, 1, bus(0, 32'h0, 32'hA000_0000), 3));
      tbl.push_back(mk(1, 32'h10, 1, 1, 32'hA000_000C, 0, 0, 0, 0, 1, bus(0, 32'h0, 32'hA000_0000), 4));
      tbl.push_back(mk(1, 32'h10, 1, 0, 0,            1, 0, 0, 0, 1, bus(0, 32'h0, 32'hA000_0000), 4));
      tbl.push_back(mk(1, 32'h10, 1, 0, 0,            1, 0, 1, 1, 1, bus(0, 32'h4, 32'hA000_0004), 3));
      tbl.push_back(mk(0, 0,      0, 0, 0,            1, 0, 0, 0, 1, bus(0, 32'h8, 32'hA000_0008), 3));
      tbl.push_back(mk(0, 0,      0, 0, 0,            1, 0, 0, 0, 1, bus(0, 32'hC, 32'hA000_000C), 2));
      tbl.push_back(mk(0, 0,      0, 1, 32'hA000_0010, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,      0, 0, 0,            1, 0, 0, 0, 1, bus(0, 32'h10, 32'hA000_0010), 1));
      tbl.push_back(mk(0, 0,      0, 0, 0,            1, 0, 0, 0, 0, 0, 0));
      run_tbl("fill");

      // 3: misaligned PC, no sram request, exception entry visible next cycle
      tbl.push_back(mk(1, 32'h1002, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0,        0, 0, 0, 1, 0, 0, 0, 1, bus(1, 32'h1002, 32'h0), 1));
      tbl.push_back(mk(0, 0,        0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      run_tbl("misalign");

      // 4: ws_ex with 3 PEND; new PC during the cancel window, cancel debt limits room
      tbl.push_back(mk(1, 32'h40, 1, 0, 0,             1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'h44, 1, 0, 0,             1, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(1, 32'h48, 1, 0, 0,             1, 0, 1, 1, 0, 0, 2));
      tbl.push_back(mk(1, 32'h4C, 1, 0, 0,             1, 1, 0, 0, 0, 0, 3));
      tbl.push_back(mk(1, 32'h80, 1, 0, 0,             1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'h84, 1, 1, 32'hDEAD_0001, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,      0, 1, 32'hDEAD_0002, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,      0, 1, 32'hDEAD_0003, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,      0, 1, 32'h2402_0080, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,      0, 0, 0,             1, 0, 0, 0, 1, bus(0, 32'h80, 32'h2402_0080), 1));
      tbl.push_back(mk(0, 0,      0, 0, 0,             1, 0, 0, 0, 0, 0, 0));
      run_tbl("flush_ex");

      // 5: ws_eret coincident with data_ok, 2 PEND -> one response still owed
      tbl.push_back(mk(1, 32'h200, 1, 0, 0,             1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'h204, 1, 0, 0,             1, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(0, 0,       0, 1, 32'hDEAD_0004, 1, 2, 0, 0, 0, 0, 2));
      tbl.push_back(mk(1, 32'h300, 1, 0, 0,             1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0,       0, 1, 32'hDEAD_0005, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,       0, 1, 32'h2403_0300, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,       0, 0, 0,             1, 0, 0, 0, 1, bus(0, 32'h300, 32'h2403_0300), 1));
      tbl.push_back(mk(0, 0,       0, 0, 0,             1, 0, 0, 0, 0, 0, 0));
      run_tbl("flush_eret");

      // 6: build 2 PEND + cancel_cnt=1, then async reset in the middle of a cycle
      tbl.push_back(mk(1, 32'h500, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0,       0, 0, 0, 1, 1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 32'h504, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(1, 32'h508, 1, 0, 0, 1, 0, 1, 1, 0, 0, 1));
      run_tbl("pre_rst");
      drive(mk(1, 32'h50C, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      #2;
      chk("pre_rst.req", BUS_W'(inst_sram_req), BUS_W'(1'b1));
      chk("pre_rst.occ", BUS_W'(fs_occupancy), BUS_W'(2));
      reset = 1'b0;
      #1;
      chk_all_zero("mid_rst");
      @(posedge clk);
      drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      tbl.push_back(mk(0, 0,       0, 1, 32'hDEAD_0006, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 32'h100, 1, 0, 0,             1, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0,       0, 1, 32'h2404_0100, 1, 0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0,       0, 0, 0,             1, 0, 0, 0, 1, bus(0, 32'h100, 32'h2404_0100), 1));
      tbl.push_back(mk(0, 0,       0, 0, 0,             1, 0, 0, 0, 0, 0, 0));
      run_tbl("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
